gcode_cmd_decoder: RTL
======================

# gcode_cmd_decoder

Sequential G-code command decoder sitting between the G-code line parser and the motion planner. Accepts one parsed G-word plus its coordinate arguments per handshake. Tracks absolute/relative positioning mode (G90/G91) and current pen position, and emits motion commands with absolute, saturated target and arc-centre coordinates. Unsupported codes are dropped and counted.

## Interface

Parameters:
- `NUM_BITS`, 8: width of the incoming G-code number (unsigned).
- `COORD_BITS`, 16: width of all coordinates, signed two's complement.
- `ERR_BITS`, 8: width of the unsupported-code counter.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  decoder can accept a word.
- `gcode`  in  NUM_BITS  G-code number (0,1,2,3,90,91 supported).
- `has_x`, `has_y`  in  1 each  X/Y argument present.
- `x`, `y`, `i`, `j`  in  COORD_BITS each  raw arguments; I/J always relative to current position.
- `out_valid`  out  1  command valid.
- `out_ready`  in  1  downstream accepts command.
- `cmd`  out  `OP_CMD_BITS`  op command (`op_cmd_t`).
- `tgt_x`, `tgt_y`  out  COORD_BITS  absolute target.
- `ctr_x`, `ctr_y`  out  COORD_BITS  absolute arc centre (0 for G0/G1).
- `sat`  out  1  any coordinate of the current command saturated.
- `rel_mode`  out  1  1 = relative (G91) mode active.
- `err_count`  out  ERR_BITS  unsupported codes seen, saturating.

## Operation

- FSM states: IDLE, CALC, OUT.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, latch all inputs, go to CALC.
- CALC: decode latched `gcode`.
  - 0/1/2/3: compute targets, go to OUT.
  - 90: `rel_mode`<=0, go to IDLE, no output.
  - 91: `rel_mode`<=1, go to IDLE, no output.
  - Other: `err_count`++ (saturate at all-ones), go to IDLE, no output.
- Target per axis:
  - Axis absent: position.
  - Absolute mode: argument.
  - Relative mode: position + argument.
- Centre: position + i / position + j for G2/G3; 0 for G0/G1.
- Additions are signed, saturating to [−2^(COORD_BITS−1), 2^(COORD_BITS−1)−1]. `sat`=1 if any add clipped.
- `cmd` mapping: 0→CMD_G00, 1→CMD_G01, 2→CMD_G02, 3→CMD_G03.
- OUT: `out_valid`=1; outputs stable until `out_ready`. On handshake, position <= (`tgt_x`,`tgt_y`) and go to IDLE.
- Reset values:
  - FSM in IDLE; position (0,0); `rel_mode`=0; `err_count`=0.
  - `cmd`=CMD_G00; `tgt`/`ctr`=0; `sat`=0; `out_valid`=0.
  - `in_ready`=0 while `reset` is high.

## Timing

- Input accepted at edge k → CALC in cycle k+1 → `out_valid` high from cycle k+2.
- Min throughput: one motion command per 3 cycles. Mode/unsupported words take 2 cycles.
- `in_ready` and `out_valid` are never both 1 (single outstanding word).
- `out_ready` held high during OUT: handshake completes at first OUT edge.
- Reset mid-operation: any state returns to IDLE next edge, pending command discarded, position/mode/counter cleared.
- `rel_mode` change is visible to the word accepted immediately after.

## Structure

- Shared package `plotter_pkg`:
  - `op_cmd_t` enum: CMD_G00=0, CMD_G01=1, CMD_G02=2, CMD_G03=3.
  - `OP_CMD_BITS`=3.
  - G-code number constants (GCODE_G90=90, GCODE_G91=91).
  - FSM state enum.
- Sub-module `coord_sat_add`: parametrised signed saturating adder (a, b → sum, sat). Four instances.

## Test plan

- After reset, G1 X=100 Y=−50 absolute → `cmd`=CMD_G01, tgt=(100,−50), `ctr`=0, `sat`=0, `out_valid` 2 cycles after accept.
- G91, then G0 X=10 (no Y) from (100,−50) → `rel_mode`=1, no output for G91; `cmd`=CMD_G00, tgt=(110,−50).
- G2 X=0 Y=0 I=5 J=−5 absolute from (20,20) → `cmd`=CMD_G02, tgt=(0,0), ctr=(25,15).
- Relative G1 X=32767 from (100,0), COORD_BITS=16 → tgt_x=32767, `sat`=1; next position 32767.
- G5, then G17, then G1 → `err_count`=2, only the G1 produces output; 300 unsupported words with ERR_BITS=8 → `err_count`=255.
- `out_ready` low 5 cycles in OUT, then reset asserted → outputs stable during stall, then `out_valid`=0, position (0,0), `rel_mode`=0 after reset.

Source files
------------

// File: rtl/plotter_pkg.sv
// plotter_pkg: shared types and constants for the plotter G-code path.
//   op_cmd_t     - motion command issued to the planner (G0..G3)
//   OP_CMD_BITS  - encoded width of op_cmd_t
//   GCODE_*      - supported G-code numbers
//   state_t      - decoder FSM state
package plotter_pkg;

    localparam int OP_CMD_BITS = 3;

    typedef enum logic [OP_CMD_BITS-1:0] {
        CMD_G00 = 3'd0,
        CMD_G01 = 3'd1,
        CMD_G02 = 3'd2,
        CMD_G03 = 3'd3
    } op_cmd_t;

    localparam int GCODE_G0  = 0;
    localparam int GCODE_G1  = 1;
    localparam int GCODE_G2  = 2;
    localparam int GCODE_G3  = 3;
    localparam int GCODE_G90 = 90;
    localparam int GCODE_G91 = 91;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/gcode_cmd_decoder_if.sv
// gcode_cmd_decoder_if: parser-side word handshake plus planner-side command
// handshake of the G-code decoder, with mode/error status.
//   in_valid/in_ready          - word handshake (parser -> decoder)
//   gcode, has_x, has_y        - parsed G-word and argument presence
//   x, y, i, j                 - raw signed arguments
//   out_valid/out_ready        - command handshake (decoder -> planner)
//   cmd, tgt_x/y, ctr_x/y, sat - absolute motion command
//   rel_mode, err_count        - status
// slave  = decoder side, master = parser/planner side.
interface gcode_cmd_decoder_if
    import plotter_pkg::*;
#(
    parameter int NUM_BITS   = 8,
    parameter int COORD_BITS = 16,
    parameter int ERR_BITS   = 8
) ();

    logic                         in_valid;
    logic                         in_ready;
    logic [NUM_BITS-1:0]          gcode;
    logic                         has_x;
    logic                         has_y;
    logic signed [COORD_BITS-1:0] x;
    logic signed [COORD_BITS-1:0] y;
    logic signed [COORD_BITS-1:0] i;
    logic signed [COORD_BITS-1:0] j;

    logic                         out_valid;
    logic                         out_ready;
    op_cmd_t                      cmd;
    logic signed [COORD_BITS-1:0] tgt_x;
    logic signed [COORD_BITS-1:0] tgt_y;
    logic signed [COORD_BITS-1:0] ctr_x;
    logic signed [COORD_BITS-1:0] ctr_y;
    logic                         sat;
    logic                         rel_mode;
    logic [ERR_BITS-1:0]          err_count;

    modport slave (
        input  in_valid, gcode, has_x, has_y, x, y, i, j, out_ready,
        output in_ready, out_valid, cmd, tgt_x, tgt_y, ctr_x, ctr_y,
               sat, rel_mode, err_count
    );

    modport master (
        output in_valid, gcode, has_x, has_y, x, y, i, j, out_ready,
        input  in_ready, out_valid, cmd, tgt_x, tgt_y, ctr_x, ctr_y,
               sat, rel_mode, err_count
    );

endinterface

// File: rtl/gcode_cmd_decoder_coord_sat_add.sv
// coord_sat_add: combinational signed saturating adder.
//   a_i, b_i  - signed W-bit operands
//   sum_o     - a_i + b_i clipped to [-2^(W-1), 2^(W-1)-1]
//   sat_o     - 1 when the true sum was clipped
module coord_sat_add #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o,
    output logic                sat_o
);

    localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    logic signed [W:0] full;

    assign full = {a_i[W-1], a_i} + {b_i[W-1], b_i};

    // Overflow shows up as the two top bits of the widened sum disagreeing;
    // the extra top bit then carries the true sign.
    always_comb begin
        sat_o = full[W] ^ full[W-1];
        sum_o = full[W-1:0];
        if (sat_o) begin
            sum_o = full[W] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/gcode_cmd_decoder.sv
// gcode_cmd_decoder: sequential G-code word decoder feeding the motion planner.
// Accepts one parsed G-word per handshake, tracks G90/G91 mode and the pen
// position, and emits absolute saturated target/arc-centre commands.
// Unsupported codes are dropped and counted (saturating).
//   clk    - rising-edge clock
//   reset  - synchronous, active-high
//   bus    - gcode_cmd_decoder_if.slave (word in, command out, status)
module gcode_cmd_decoder
    import plotter_pkg::*;
#(
    parameter int NUM_BITS   = 8,
    parameter int COORD_BITS = 16,
    parameter int ERR_BITS   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    gcode_cmd_decoder_if.slave     bus
);

    localparam logic [NUM_BITS-1:0] G90 = NUM_BITS'(GCODE_G90);
    localparam logic [NUM_BITS-1:0] G91 = NUM_BITS'(GCODE_G91);
    localparam logic [NUM_BITS-1:0] G2  = NUM_BITS'(GCODE_G2);
    localparam logic [NUM_BITS-1:0] G3  = NUM_BITS'(GCODE_G3);

    typedef logic signed [COORD_BITS-1:0] coord_t;

    state_t              state_q;
    logic [NUM_BITS-1:0] gcode_q;
    logic                has_x_q, has_y_q;
    coord_t              x_q, y_q, i_q, j_q;
    coord_t              pos_x_q, pos_y_q;
    logic                rel_q;
    logic [ERR_BITS-1:0] err_q;

    logic                out_valid_q;
    op_cmd_t             cmd_q;
    coord_t              tgt_x_q, tgt_y_q, ctr_x_q, ctr_y_q;
    logic                sat_q;

    // Adder results against the current position
    coord_t sum_tx, sum_ty, sum_cx, sum_cy;
    logic   sat_tx, sat_ty, sat_cx, sat_cy;

    coord_sat_add #(.W(COORD_BITS)) u_add_tx (.a_i(pos_x_q), .b_i(x_q), .sum_o(sum_tx), .sat_o(sat_tx));
    coord_sat_add #(.W(COORD_BITS)) u_add_ty (.a_i(pos_y_q), .b_i(y_q), .sum_o(sum_ty), .sat_o(sat_ty));
    coord_sat_add #(.W(COORD_BITS)) u_add_cx (.a_i(pos_x_q), .b_i(i_q), .sum_o(sum_cx), .sat_o(sat_cx));
    coord_sat_add #(.W(COORD_BITS)) u_add_cy (.a_i(pos_y_q), .b_i(j_q), .sum_o(sum_cy), .sat_o(sat_cy));

    // Next command values, consumed in CALC
    logic    is_motion, is_arc;
    op_cmd_t cmd_d;
    coord_t  tgt_x_d, tgt_y_d, ctr_x_d, ctr_y_d;
    logic    sat_d;

    always_comb begin
        is_motion = (gcode_q[NUM_BITS-1:2] == '0);
        is_arc    = (gcode_q == G2) || (gcode_q == G3);
        cmd_d     = op_cmd_t'({1'b0, gcode_q[1:0]});

        // Absent axis holds position; absolute takes the raw argument
        // (cannot clip); only the relative add can saturate.
        tgt_x_d = !has_x_q ? pos_x_q : (rel_q ? sum_tx : x_q);
        tgt_y_d = !has_y_q ? pos_y_q : (rel_q ? sum_ty : y_q);
        ctr_x_d = is_arc ? sum_cx : '0;
        ctr_y_d = is_arc ? sum_cy : '0;

        sat_d = (has_x_q && rel_q && sat_tx) ||
                (has_y_q && rel_q && sat_ty) ||
                (is_arc && (sat_cx || sat_cy));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gcode_q     <= '0;
            has_x_q     <= 1'b0;
            has_y_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            rel_q       <= 1'b0;
            err_q       <= '0;
            out_valid_q <= 1'b0;
            cmd_q       <= CMD_G00;
            tgt_x_q     <= '0;
            tgt_y_q     <= '0;
            ctr_x_q     <= '0;
            ctr_y_q     <= '0;
            sat_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        gcode_q <= bus.gcode;
                        has_x_q <= bus.has_x;
                        has_y_q <= bus.has_y;
                        x_q     <= bus.x;
                        y_q     <= bus.y;
                        i_q     <= bus.i;
                        j_q     <= bus.j;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (is_motion) begin
                        cmd_q       <= cmd_d;
                        tgt_x_q     <= tgt_x_d;
                        tgt_y_q     <= tgt_y_d;
                        ctr_x_q     <= ctr_x_d;
                        ctr_y_q     <= ctr_y_d;
                        sat_q       <= sat_d;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        if (gcode_q == G90) begin
                            rel_q <= 1'b0;
                        end else if (gcode_q == G91) begin
                            rel_q <= 1'b1;
                        end else if (err_q != '1) begin
                            err_q <= err_q + 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        pos_x_q     <= tgt_x_q;
                        pos_y_q     <= tgt_y_q;
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // in_ready is forced low for the whole time reset is asserted, not just
    // after the first reset edge.
    assign bus.in_ready  = (state_q == IDLE) && !reset;
    assign bus.out_valid = out_valid_q;
    assign bus.cmd       = cmd_q;
    assign bus.tgt_x     = tgt_x_q;
    assign bus.tgt_y     = tgt_y_q;
    assign bus.ctr_x     = ctr_x_q;
    assign bus.ctr_y     = ctr_y_q;
    assign bus.sat       = sat_q;
    assign bus.rel_mode  = rel_q;
    assign bus.err_count = err_q;

endmodule
